// File: rtl/trap_ctrl.sv
// Trap sequencer ahead of the machine-mode CSR file: selects one trap/interrupt/mret
// per MEM instruction, strobes the CSR file, then redirects the PC and flushes.
module trap_ctrl #(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_mem,
    input  logic [XLEN-1:0] pc_mem,
    input  logic [XLEN-1:0] inst_mem,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            exc_fetch_mis,
    input  logic            exc_illegal,
    input  logic            exc_ebreak,
    input  logic            exc_ecall,
    input  logic            exc_load_mis,
    input  logic            exc_store_mis,
    input  logic            mret_mem,
    input  logic            ext_int,
    input  logic            timer_int,
    input  logic            csr_w,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc_out,
    output logic            exception,
    output logic            allow_interrupt,
    output logic            mret,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic            stall,
    output logic            flush,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_REDIR  = 2'd3;

    localparam logic [1:0] K_EXC  = 2'd0;
    localparam logic [1:0] K_INT  = 2'd1;
    localparam logic [1:0] K_MRET = 2'd2;

    localparam logic [XLEN-1:0] CAUSE_EXT   = {1'b1, (XLEN-1)'(11)};
    localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, (XLEN-1)'(7)};

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [1:0]             r_kind;
    logic [XLEN-1:0]        r_epc, r_cause, r_tval;
    logic [XLEN-1:0]        r_cause_q, r_tval_q;

    logic            w_irq_ext;
    logic            w_event;
    logic [1:0]      w_kind;
    logic [XLEN-1:0] w_cause, w_tval;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_base;
    logic            w_unused;

    assign w_irq_ext = r_sync[SYNC_STAGES-1];
    assign w_base    = {mtvec[XLEN-1:2], 2'b00};
    assign w_unused  = &{1'b0, mstatus[XLEN-1:4], mstatus[2:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= ext_int;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Priority encoder: interrupts, then exceptions in architectural order, then mret.
    always_comb begin
        w_event = 1'b0;
        w_kind  = K_EXC;
        w_cause = '0;
        w_tval  = '0;
        if (valid_mem) begin
            if (mstatus[3] && w_irq_ext) begin
                w_event = 1'b1; w_kind = K_INT; w_cause = CAUSE_EXT;
            end else if (mstatus[3] && timer_int) begin
                w_event = 1'b1; w_kind = K_INT; w_cause = CAUSE_TIMER;
            end else if (exc_fetch_mis) begin
                w_event = 1'b1; w_cause = XLEN'(0);  w_tval = pc_mem;
            end else if (exc_illegal) begin
                w_event = 1'b1; w_cause = XLEN'(2);  w_tval = inst_mem;
            end else if (exc_ebreak) begin
                w_event = 1'b1; w_cause = XLEN'(3);  w_tval = pc_mem;
            end else if (exc_ecall) begin
                w_event = 1'b1; w_cause = XLEN'(11);
            end else if (exc_load_mis) begin
                w_event = 1'b1; w_cause = XLEN'(4);  w_tval = mem_addr;
            end else if (exc_store_mis) begin
                w_event = 1'b1; w_cause = XLEN'(6);  w_tval = mem_addr;
            end else if (mret_mem) begin
                w_event = 1'b1; w_kind = K_MRET;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_event) w_state_nxt = csr_w ? S_WAIT : S_COMMIT;
            S_WAIT:   if (!csr_w) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_REDIR;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_kind    <= K_EXC;
            r_epc     <= '0;
            r_cause   <= '0;
            r_tval    <= '0;
            r_cause_q <= '0;
            r_tval_q  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_event) begin
                r_kind  <= w_kind;
                r_epc   <= pc_mem;
                r_cause <= w_cause;
                r_tval  <= w_tval;
            end
            // Shadow copies let mret rewrite mcause/mtval with their current values.
            if (r_state == S_COMMIT && r_kind != K_MRET) begin
                r_cause_q <= r_cause;
                r_tval_q  <= r_tval;
            end
        end
    end

    always_comb begin
        exception       = 1'b0;
        allow_interrupt = 1'b0;
        mret            = 1'b0;
        mepc            = '0;
        mcause          = '0;
        mtval           = '0;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        case (r_state)
            S_IDLE: stall = w_event & csr_w;
            S_WAIT: stall = 1'b1;
            S_COMMIT: begin
                stall = 1'b1;
                flush = 1'b1;
                if (r_kind == K_MRET) begin
                    mret   = 1'b1;
                    mepc   = mepc_out;
                    mcause = r_cause_q;
                    mtval  = r_tval_q;
                end else begin
                    exception       = (r_kind == K_EXC);
                    allow_interrupt = (r_kind == K_INT);
                    mepc            = r_epc;
                    mcause          = r_cause;
                    mtval           = r_tval;
                end
            end
            default: begin
                redirect = 1'b1;
                flush    = 1'b1;
                if (r_kind == K_MRET)
                    redirect_pc = mepc_out;
                else if (r_kind == K_INT && mtvec[1:0] == 2'b01)
                    redirect_pc = w_base + {{(XLEN-7){1'b0}}, r_cause[4:0], 2'b00};
                else
                    redirect_pc = w_base;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: each step drives inputs after a rising edge and
// checks every output at the following falling edge against hand-computed values.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_mem;
    logic [31:0] pc_mem, inst_mem, mem_addr;
    logic        exc_fetch_mis, exc_illegal, exc_ebreak, exc_ecall, exc_load_mis, exc_store_mis;
    logic        mret_mem, ext_int, timer_int, csr_w;
    logic [31:0] mstatus, mtvec, mepc_out;
    logic        exception, allow_interrupt, mret;
    logic [31:0] mepc, mcause, mtval;
    logic        stall, flush, redirect;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .valid_mem(valid_mem), .pc_mem(pc_mem), .inst_mem(inst_mem),
        .mem_addr(mem_addr), .exc_fetch_mis(exc_fetch_mis), .exc_illegal(exc_illegal),
        .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall), .exc_load_mis(exc_load_mis),
        .exc_store_mis(exc_store_mis), .mret_mem(mret_mem), .ext_int(ext_int),
        .timer_int(timer_int), .csr_w(csr_w), .mstatus(mstatus), .mtvec(mtvec),
        .mepc_out(mepc_out), .exception(exception), .allow_interrupt(allow_interrupt),
        .mret(mret), .mepc(mepc), .mcause(mcause), .mtval(mtval), .stall(stall),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check all outputs at the falling edge, then advance to just after the next rising edge.
    task automatic look(input string tag, input logic ex, input logic ai, input logic mr,
                        input logic [31:0] ep, input logic [31:0] mc, input logic [31:0] mt,
                        input logic st, input logic fl, input logic rd, input logic [31:0] rp);
        @(negedge clk);
        chk({tag, ".exception"},       32'(exception),       32'(ex));
        chk({tag, ".allow_interrupt"}, 32'(allow_interrupt), 32'(ai));
        chk({tag, ".mret"},            32'(mret),            32'(mr));
        chk({tag, ".mepc"},            mepc,                 ep);
        chk({tag, ".mcause"},          mcause,               mc);
        chk({tag, ".mtval"},           mtval,                mt);
        chk({tag, ".stall"},           32'(stall),           32'(st));
        chk({tag, ".flush"},           32'(flush),           32'(fl));
        chk({tag, ".redirect"},        32'(redirect),        32'(rd));
        chk({tag, ".redirect_pc"},     redirect_pc,          rp);
        @(posedge clk);
        #1;
    endtask

    task automatic look0(input string tag);
        look(tag, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    task automatic clr_ev();
        valid_mem = 0; exc_fetch_mis = 0; exc_illegal = 0; exc_ebreak = 0; exc_ecall = 0;
        exc_load_mis = 0; exc_store_mis = 0; mret_mem = 0; timer_int = 0; ext_int = 0; csr_w = 0;
    endtask

    initial begin
        rst = 0;
        clr_ev();
        pc_mem = 0; inst_mem = 0; mem_addr = 0;
        mstatus = 0; mtvec = 0; mepc_out = 0;
        @(posedge clk); #1;
        look0("reset_a");
        look0("reset_b");
        rst = 1;
        look0("idle");

        // Illegal instruction, direct-mode vector
        mstatus = 32'h88; mtvec = 32'h100;
        valid_mem = 1; pc_mem = 32'h40; inst_mem = 32'hFFFF_FFFF; exc_illegal = 1;
        look0("ill_detect");
        clr_ev();
        look("ill_commit", 1, 0, 0, 32'h40, 32'h2, 32'hFFFF_FFFF, 1, 1, 0, 32'h0);
        look("ill_redir",  0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h100);
        look0("ill_after");

        // mret preserves the previously committed cause/tval
        mepc_out = 32'h84; valid_mem = 1; pc_mem = 32'h60; mret_mem = 1;
        look0("mret_detect");
        clr_ev();
        look("mret_commit", 0, 0, 1, 32'h84, 32'h2, 32'hFFFF_FFFF, 1, 1, 0, 32'h0);
        look("mret_redir",  0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h84);
        look0("mret_after");

        // mret alongside ebreak: the exception wins
        valid_mem = 1; pc_mem = 32'h50; mret_mem = 1; exc_ebreak = 1;
        look0("ebrk_detect");
        clr_ev();
        look("ebrk_commit", 1, 0, 0, 32'h50, 32'h3, 32'h50, 1, 1, 0, 32'h0);
        look("ebrk_redir",  0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h100);

        // Timer interrupt, vectored mode: 0x200 + 4*7
        mtvec = 32'h201; valid_mem = 1; pc_mem = 32'h80; timer_int = 1;
        look0("tmr_detect");
        clr_ev();
        look("tmr_commit", 0, 1, 0, 32'h80, 32'h8000_0007, 32'h0, 1, 1, 0, 32'h0);
        look("tmr_redir",  0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h21C);

        // Timer masked by MIE=0
        mstatus = 32'h80; valid_mem = 1; timer_int = 1;
        for (int i = 0; i < 20; i++) look0("tmr_masked");
        clr_ev();
        mstatus = 32'h88; mtvec = 32'h100;

        // ecall during a CSR write: stalled in WAIT, later events ignored
        valid_mem = 1; pc_mem = 32'h90; exc_ecall = 1; csr_w = 1;
        look("ecall_idle", 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        clr_ev();
        csr_w = 1; valid_mem = 1; pc_mem = 32'hDEAD; exc_illegal = 1;
        look("ecall_wait1", 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        look("ecall_wait2", 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        csr_w = 0;
        look("ecall_wait3", 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        clr_ev();
        look("ecall_commit", 1, 0, 0, 32'h90, 32'd11, 32'h0, 1, 1, 0, 32'h0);
        look("ecall_redir",  0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h100);

        // External interrupt beats timer and illegal once through the synchronizer
        ext_int = 1;
        look0("ext_sync1");
        look0("ext_sync2");
        valid_mem = 1; pc_mem = 32'hA0; inst_mem = 32'h1234; timer_int = 1; exc_illegal = 1;
        look0("ext_detect");
        clr_ev();
        look("ext_commit", 0, 1, 0, 32'hA0, 32'h8000_000B, 32'h0, 1, 1, 0, 32'h0);
        look("ext_redir",  0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h100);
        look0("ext_after1");
        look0("ext_after2");

        // Reset during COMMIT aborts the sequence
        valid_mem = 1; pc_mem = 32'hB0; inst_mem = 32'h0; exc_illegal = 1;
        look0("rst_detect");
        clr_ev();
        rst = 0;
        look("rst_commit", 1, 0, 0, 32'hB0, 32'h2, 32'h0, 1, 1, 0, 32'h0);
        rst = 1;
        look0("rst_after1");
        look0("rst_after2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
